// File: rtl/mult32x32_fast_fsm.sv
// Control FSM for the 16x16-based 32x32 multiplier: sequences one partial
// product per cycle, skipping zero partial products when MULT_FAST_SKIP_EN is defined.
// Ports: clk, reset (async, active-high), start, a_msw_is_0, b_msw_is_0 in;
//        busy, done, a_sel, b_sel, shift_sel[1:0], upd_prod, clr_prod out.
module mult32x32_fast_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_msw_is_0,
    input  logic       b_msw_is_0,
    output logic       busy,
    output logic       done,
    output logic       a_sel,
    output logic       b_sel,
    output logic [1:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
);

`ifdef MULT_FAST_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_A0B0,
        S_A0B1,
        S_A1B0,
        S_A1B1
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   skip_a, skip_b;

    // With skipping disabled the flags are masked off, forcing the full
    // four-step sequence.
    assign skip_a = SKIP_EN & a_msw_is_0;
    assign skip_b = SKIP_EN & b_msw_is_0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        upd_prod  = 1'b1;
        clr_prod  = 1'b0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                upd_prod = 1'b0;
                // Mealy: clear on the same edge that accepts start.
                clr_prod = start;
                if (start) state_d = S_A0B0;
            end
            S_A0B0: begin
                if (!skip_b)      state_d = S_A0B1;
                else if (!skip_a) state_d = S_A1B0;
                else              state_d = S_IDLE;
            end
            S_A0B1: begin
                b_sel     = 1'b1;
                shift_sel = 2'b01;
                if (!skip_a) state_d = S_A1B0;
                else         state_d = S_IDLE;
            end
            S_A1B0: begin
                a_sel     = 1'b1;
                shift_sel = 2'b01;
                if (!skip_b) state_d = S_A1B1;
                else         state_d = S_IDLE;
            end
            S_A1B1: begin
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b10;
                state_d   = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                busy     = 1'b0;
                upd_prod = 1'b0;
            end
        endcase
        // Pulse done on the edge that leaves the last step.
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

    assign done = done_q;

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// Bench for mult32x32_fast_fsm: a behavioural datapath wraps the FSM and a
// scoreboard checks product and start-to-done latency of directed vectors.
module tb_mult32x32_fast_fsm;

`ifdef MULT_FAST_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, a_sel, b_sel, upd_prod, clr_prod;
    logic [1:0]  shift_sel;
    logic [31:0] a, b;
    logic        a_msw_is_0, b_msw_is_0;
    logic [63:0] prod;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          c0;
        string       name;
    } item_t;
    item_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_msw_is_0 = (a[31:16] == 16'h0);
    assign b_msw_is_0 = (b[31:16] == 16'h0);

    mult32x32_fast_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_msw_is_0 (a_msw_is_0),
        .b_msw_is_0 (b_msw_is_0),
        .busy       (busy),
        .done       (done),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .shift_sel  (shift_sel),
        .upd_prod   (upd_prod),
        .clr_prod   (clr_prod)
    );

    // Behavioural datapath driven by the FSM controls.
    logic [31:0] ah, bh, pp;
    logic [63:0] pps;
    always_comb begin
        ah  = {16'h0, (a_sel ? a[31:16] : a[15:0])};
        bh  = {16'h0, (b_sel ? b[31:16] : b[15:0])};
        pp  = ah * bh;
        pps = {32'h0, pp};
        if (shift_sel == 2'b01)      pps = {16'h0, pp, 16'h0};
        else if (shift_sel == 2'b10) pps = {pp, 32'h0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         prod <= 64'h0;
        else if (clr_prod) prod <= 64'h0;
        else if (upd_prod) prod <= prod + pps;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat(input int n);
        return SKIP ? n + 1 : 5;
    endfunction

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        item_t it;
        if (busy) chk("shift_sel_legal", {63'h0, shift_sel == 2'b11}, 64'h0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'h1, 64'h0);
            end else begin
                it = sb.pop_front();
                chk({it.name, "_prod"}, prod, it.prod);
                chk({it.name, "_lat"}, 64'(cyc - it.c0), 64'(it.lat));
            end
        end
    end

    // Called just after a negedge; returns one negedge later with start low.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] ep, input int n,
                         input string nm, input bit push);
        item_t it;
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) begin
            it.prod = ep;
            it.lat  = lat(n);
            it.c0   = cyc;
            it.name = nm;
            sb.push_back(it);
        end
        #1;
        chk({nm, "_clr"}, {63'h0, clr_prod}, 64'h1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_seen"}, {63'h0, done}, 64'h1);
    endtask

    logic [1:0] sh_exp [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_upd", {63'h0, upd_prod}, 64'h0);
        chk("rst_sel", {61'h0, a_sel, b_sel, shift_sel}, 64'h0);
        chk("rst_clr0", {63'h0, clr_prod}, 64'h0);
        start = 1'b1;
        #1;
        chk("rst_clr1", {63'h0, clr_prod}, 64'h1);
        chk("rst_busy_start", {63'h0, busy}, 64'h0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        issue(32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1,
              "small", 1'b1);
        wait_done("small");
        @(negedge clk);

        issue(32'h0001_0000, 32'h0000_0003, 64'h0000_0000_0003_0000, 2,
              "a_hi", 1'b1);
        wait_done("a_hi");
        @(negedge clk);

        issue(32'h0000_0002, 32'h0003_0000, 64'h0000_0000_0006_0000, 2,
              "b_hi", 1'b1);
        wait_done("b_hi");
        @(negedge clk);

        issue(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1,
              "lo_max", 1'b1);
        wait_done("lo_max");
        @(negedge clk);

        // Full multiply with a stray start pulse, then back-to-back.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4,
              "full", 1'b1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("full_shift%0d", k), {62'h0, shift_sel},
                {62'h0, sh_exp[k-1]});
            chk($sformatf("full_busy%0d", k), {63'h0, busy}, 64'h1);
            start = (k == 2 || k == 3);
            #1;
            chk($sformatf("full_clr%0d", k), {63'h0, clr_prod}, 64'h0);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("full");
        issue(32'h1234_5678, 32'h0000_0009, 64'h0000_0000_A3D7_0A38, 2,
              "b2b", 1'b1);
        wait_done("b2b");
        @(negedge clk);

        // Reset during A0B1 aborts without a done pulse.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 4, "abort", 1'b0);
        @(negedge clk);
        chk("abort_in_a0b1", {62'h0, a_sel, b_sel}, 64'h1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_upd", {63'h0, upd_prod}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_prod", prod, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd9, 64'd63, 1, "seven_nine", 1'b1);
        wait_done("seven_nine");
        repeat (8) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult32x32_fast_fsm.md
# mult32x32_fast_fsm

Control FSM that sequences the 16x16-based 32x32 multiply datapath (`mult32x32_fast_arith`). It accepts a start request and drives the datapath select, shift, update and clear controls for one partial product per cycle. It uses the datapath's MSW-is-zero flags to skip partial products that are known to be zero. It reports progress with `busy` and a one-cycle `done` pulse, and sits beside the datapath inside the top-level multiplier wrapper.

## Interface
- No parameters.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a new multiply; sampled only in IDLE.
- `a_msw_is_0` input 1: from datapath; `a[31:16]==0`.
- `b_msw_is_0` input 1: from datapath; `b[31:16]==0`.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle pulse; the product register holds the final result.
- `a_sel` output 1: 0 selects `a[15:0]`, 1 selects `a[31:16]`.
- `b_sel` output 1: 0 selects `b[15:0]`, 1 selects `b[31:16]`.
- `shift_sel` output 2: 00 is <<0, 01 is <<16, 10 is <<32; 11 is never driven.
- `upd_prod` output 1: accumulate the shifted partial product into the product register.
- `clr_prod` output 1: clear the product register; only asserted with `upd_prod`=0.

## Operation
- States: IDLE, A0B0, A0B1, A1B0, A1B1. Encoding is free; each non-IDLE state is exactly one accumulation cycle.
- IDLE outputs:
  - `busy`=0, `upd_prod`=0.
  - `a_sel`=0, `b_sel`=0, `shift_sel`=00.
  - `clr_prod`=`start`. This is a Mealy output, so the product is cleared on the same edge that accepts `start`.
- IDLE transitions: `start`=1 goes to A0B0; otherwise stay in IDLE.
- Step states all drive `upd_prod`=1, `clr_prod`=0, `busy`=1:
  - A0B0: `a_sel`=0, `b_sel`=0, `shift_sel`=00.
  - A0B1: `a_sel`=0, `b_sel`=1, `shift_sel`=01.
  - A1B0: `a_sel`=1, `b_sel`=0, `shift_sel`=01.
  - A1B1: `a_sel`=1, `b_sel`=1, `shift_sel`=10.
- Transitions with skip (flag `a0`=`a_msw_is_0`, `b0`=`b_msw_is_0`):
  - A0B0 goes to A0B1 if !`b0`; else to A1B0 if !`a0`; else to IDLE.
  - A0B1 goes to A1B0 if !`a0`; else to IDLE.
  - A1B0 goes to A1B1 if !`b0`; else to IDLE.
  - A1B1 goes to IDLE.
- `done` is a registered flag, set on every step-to-IDLE transition and cleared on the following edge.
- `start` is ignored while `busy`=1.
- Operands `a` and `b` must be held stable by the requester from the `start` cycle until `done`. The flags are read combinationally every step cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `upd_prod`=0, `a_sel`=0, `b_sel`=0, `shift_sel`=00.
- `clr_prod` follows `start` during and after reset.
- Cycle numbering: `start` is high in IDLE in cycle 0.
  - Cycles 1..N are steps, with N from 1 to 4.
  - Cycle N+1 is IDLE with `done`=1, and the product is final.
- Latency is N+1 cycles from `start` to `done`:
  - N=4 with both MSWs nonzero.
  - N=2 with exactly one MSW zero.
  - N=1 with both MSWs zero.
- Back-to-back operation: `start`=1 in the `done` cycle is accepted. `clr_prod`=1 in that cycle, and the next operation follows with no bubble.
- Reset mid-operation: the FSM forces IDLE immediately. `done` is not pulsed, and the datapath (same `reset`) clears the product to 0.
- `shift_sel`=11 is never driven in any state.

## Configuration
- `MULT_FAST_SKIP_EN` defined: skip transitions as above.
- `MULT_FAST_SKIP_EN` undefined:
  - The flags are ignored and the sequence is always A0B0, A0B1, A1B0, A1B1, then IDLE.
  - N=4 and `done` arrives in cycle 5.
  - Products are identical to the skip build.

## Test plan
- Skip build, `a`=0x0000_1234, `b`=0x0000_5678, `start` in cycle 0:
  - Only A0B0 is visited.
  - `done` in cycle 2; product = 0x0000_0000_0626_0060.
- `a`=`b`=0xFFFF_FFFF:
  - All four steps with `shift_sel` sequence 00, 01, 01, 10.
  - `done` in cycle 5; product = 0xFFFF_FFFE_0000_0001.
- `a`=0x0001_0000, `b`=0x0000_0003:
  - Skip build: A0B0 then A1B0, `done` in cycle 3.
  - Non-skip build: `done` in cycle 5.
  - Both builds: product = 0x0000_0000_0003_0000.
- Pulse `start` again in cycles 2–3 of a full multiply:
  - The pulse is ignored; state and outputs are unchanged and `done` stays in cycle 5.
  - Then assert `start` in the `done` cycle: `clr_prod`=1 and the second result is correct with no bubble.
- Assert `reset` during A0B1:
  - `busy`, `upd_prod` and `done` drop immediately and the product becomes 0.
  - After release, a fresh multiply of 7×9 yields 63.
